// File: rtl/dist_8_pkg.sv
// Shared definitions for the DIST_8 pixel-to-weight distance engine:
// datapath widths, FSM state encoding and a channel difference helper.
package dist_8_pkg;

  localparam int PIX_W  = 24;  // one RGB pixel or weight, R=[23:16] G=[15:8] B=[7:0]
  localparam int CH_W   = 8;   // one colour channel
  localparam int DIST_W = 11;  // wide enough for 3*255 and for 255+2*255+255
  localparam int N_W    = 8;   // weight bank entries
  localparam int IDX_W  = 3;   // weight bank index

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Absolute difference of two unsigned channel values.
  function automatic logic [CH_W-1:0] abs_diff(input logic [CH_W-1:0] a,
                                               input logic [CH_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/dist_8_if.sv
// Pixel / weight bus of DIST_8. The master offers pixels and weight writes;
// the slave (the distance engine) returns distances and the weight bank.
interface dist_8_if;
  import dist_8_pkg::*;

  logic              w_load;
  logic [IDX_W-1:0]  w_idx;
  logic [PIX_W-1:0]  w_data;
  logic              in_valid;
  logic [PIX_W-1:0]  pixel;
  logic              in_ready;
  logic              out_valid;
  logic [DIST_W-1:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic [PIX_W-1:0]  w0, w1, w2, w3, w4, w5, w6, w7;

  modport master (
    output w_load, w_idx, w_data, in_valid, pixel,
    input  in_ready, out_valid,
    input  d0, d1, d2, d3, d4, d5, d6, d7,
    input  w0, w1, w2, w3, w4, w5, w6, w7
  );

  modport slave (
    input  w_load, w_idx, w_data, in_valid, pixel,
    output in_ready, out_valid,
    output d0, d1, d2, d3, d4, d5, d6, d7,
    output w0, w1, w2, w3, w4, w5, w6, w7
  );

endinterface

// File: rtl/dist_8_pix_dist.sv
// PIX_DIST: combinational L1 distance between one pixel and one weight.
// Build option: DIST_8_GREEN_WEIGHT_EN doubles the green channel term.
module dist_8_pix_dist
  import dist_8_pkg::*;
(
  input  logic [PIX_W-1:0]  pixel_i,
  input  logic [PIX_W-1:0]  weight_i,
  output logic [DIST_W-1:0] dist_o
);

  logic [DIST_W-1:0] dr_d, dg_d, db_d;

  // Per-channel absolute differences, zero-extended, then summed.
  // NOTE: every output of an always_comb is assigned on every path, so no latch can form.
  always_comb begin
    dr_d = DIST_W'(abs_diff(pixel_i[3*CH_W-1:2*CH_W], weight_i[3*CH_W-1:2*CH_W]));
    dg_d = DIST_W'(abs_diff(pixel_i[2*CH_W-1:CH_W],   weight_i[2*CH_W-1:CH_W]));
    db_d = DIST_W'(abs_diff(pixel_i[CH_W-1:0],        weight_i[CH_W-1:0]));
`ifdef DIST_8_GREEN_WEIGHT_EN
    dist_o = dr_d + (dg_d << 1) + db_d;
`else
    dist_o = dr_d + dg_d + db_d;
`endif
  end

endmodule

// File: rtl/dist_8.sv
// DIST_8: accepts one pixel, then spends eight cycles computing its distance
// to each of eight stored weights with a single shared PIX_DIST, and pulses
// out_valid when all eight results are registered. Build option:
// DIST_8_GREEN_WEIGHT_EN (green-weighted distance, same timing).
module dist_8
  import dist_8_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  dist_8_if.slave  bus
);

  state_e            state_q;
  logic [IDX_W-1:0]  cnt_q;
  logic [PIX_W-1:0]  pix_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [PIX_W-1:0]  bank_q [N_W];
  logic [DIST_W-1:0] dist_q [N_W];

  logic              accept_d;
  logic              wload_d;
  logic [DIST_W-1:0] dist_d;

  // Pixel and weight writes are only honoured while idle.
  assign accept_d = bus.in_valid && in_ready_q;
  assign wload_d  = bus.w_load   && in_ready_q;

  // One distance unit, stepped through the bank by the CALC counter.
  dist_8_pix_dist u_pix_dist (
    .pixel_i  (pix_q),
    .weight_i (bank_q[cnt_q]),
    .dist_o   (dist_d)
  );

  // Weight bank: written only by an accepted w_load.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  // NOTE: the bank is reset (not left as bare RAM) because it drives w0..w7 directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_W; k++) bank_q[k] <= '0;
    end else if (wload_d) begin
      bank_q[bus.w_idx] <= bus.w_data;
    end
  end

  // Control FSM with registered in_ready / out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pix_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            pix_q      <= bus.pixel;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == IDX_W'(N_W - 1)) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Result registers: one entry per CALC cycle, others hold their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_W; k++) dist_q[k] <= '0;
    end else if (state_q == CALC) begin
      dist_q[cnt_q] <= dist_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;

  assign bus.d0 = dist_q[0];
  assign bus.d1 = dist_q[1];
  assign bus.d2 = dist_q[2];
  assign bus.d3 = dist_q[3];
  assign bus.d4 = dist_q[4];
  assign bus.d5 = dist_q[5];
  assign bus.d6 = dist_q[6];
  assign bus.d7 = dist_q[7];

  assign bus.w0 = bank_q[0];
  assign bus.w1 = bank_q[1];
  assign bus.w2 = bank_q[2];
  assign bus.w3 = bank_q[3];
  assign bus.w4 = bank_q[4];
  assign bus.w5 = bank_q[5];
  assign bus.w6 = bank_q[6];
  assign bus.w7 = bank_q[7];

endmodule

// File: tb/tb_dist_8.sv
// Self-checking bench for DIST_8: directed scenarios plus random traffic,
// checked by a scoreboard fed from a cycle-level reference model.
// Honours DIST_8_GREEN_WEIGHT_EN in its expected values.
module tb_dist_8;
  import dist_8_pkg::*;

  logic clk = 1'b0;
  logic rst;

  dist_8_if bus ();

  dist_8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_W-1:0][DIST_W-1:0] d;
    int                         acc;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;
  int   ov_cnt   = 0;
  bit   chk_en   = 1'b0;

  // Reference model state.
  logic [PIX_W-1:0]  bank_m [N_W];
  logic [DIST_W-1:0] d_m    [N_W];
  logic [DIST_W-1:0] pend_m [N_W];
  int                busy_m = 0;   // cycles until idle again; 0 = ready
  exp_t              exp_q [$];
  exp_t              mon_e;

  logic [DIST_W-1:0] d_dut [N_W];
  logic [PIX_W-1:0]  w_dut [N_W];
  assign d_dut[0] = bus.d0;  assign d_dut[1] = bus.d1;
  assign d_dut[2] = bus.d2;  assign d_dut[3] = bus.d3;
  assign d_dut[4] = bus.d4;  assign d_dut[5] = bus.d5;
  assign d_dut[6] = bus.d6;  assign d_dut[7] = bus.d7;
  assign w_dut[0] = bus.w0;  assign w_dut[1] = bus.w1;
  assign w_dut[2] = bus.w2;  assign w_dut[3] = bus.w3;
  assign w_dut[4] = bus.w4;  assign w_dut[5] = bus.w5;
  assign w_dut[6] = bus.w6;  assign w_dut[7] = bus.w7;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Distance straight from the definition: sum of channel |differences|.
  function automatic logic [DIST_W-1:0] ref_dist(input logic [PIX_W-1:0] p,
                                                 input logic [PIX_W-1:0] w);
    int s;
    s = 0;
    for (int c = 0; c < 3; c++) begin
      int a;
      int b;
      int m;
      a = int'(p[c*8 +: 8]);
      b = int'(w[c*8 +: 8]);
      m = 1;
`ifdef DIST_8_GREEN_WEIGHT_EN
      if (c == 1) m = 2;
`endif
      s += m * ((a > b) ? (a - b) : (b - a));
    end
    return DIST_W'(s);
  endfunction

  // Advance the model by one rising edge using the inputs the bench drove.
  task automatic model_step();
    exp_t e;
    edge_cnt++;
    if (rst) begin
      for (int k = 0; k < N_W; k++) begin
        bank_m[k] = '0;
        d_m[k]    = '0;
      end
      busy_m = 0;
      exp_q.delete();
    end else if (busy_m >= 2) begin
      d_m[9 - busy_m] = pend_m[9 - busy_m];
      busy_m--;
    end else if (busy_m == 1) begin
      busy_m = 0;
    end else begin
      if (bus.w_load) bank_m[bus.w_idx] = bus.w_data;
      if (bus.in_valid) begin
        for (int k = 0; k < N_W; k++) begin
          pend_m[k] = ref_dist(bus.pixel, bank_m[k]);
          e.d[k]    = pend_m[k];
        end
        e.acc = edge_cnt;
        exp_q.push_back(e);
        busy_m = 9;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rst          = 1'b0;
    bus.w_load   = 1'b0;
    bus.w_idx    = '0;
    bus.w_data   = '0;
    bus.in_valid = 1'b0;
    bus.pixel    = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_w(input int idx, input logic [PIX_W-1:0] data);
    bus.w_load = 1'b1;
    bus.w_idx  = IDX_W'(idx);
    bus.w_data = data;
    tick();
    bus.w_load = 1'b0;
  endtask

  task automatic send_pix(input logic [PIX_W-1:0] p);
    bus.in_valid = 1'b1;
    bus.pixel    = p;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy_m != 0; i++) tick();
  endtask

  task automatic check_table(input string name, input logic [DIST_W-1:0] tbl [N_W]);
    for (int k = 0; k < N_W; k++)
      check($sformatf("%s_d%0d", name, k), 32'(d_dut[k]), 32'(tbl[k]));
  endtask

  // Monitor / scoreboard: compares DUT against the model away from the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 32'(bus.in_ready), 32'(busy_m == 0));
      check("out_valid", 32'(bus.out_valid), 32'(busy_m == 1));
      for (int k = 0; k < N_W; k++) begin
        check($sformatf("d_hold%0d", k), 32'(d_dut[k]), 32'(d_m[k]));
        check($sformatf("w_bank%0d", k), 32'(w_dut[k]), 32'(bank_m[k]));
      end
      if (bus.out_valid === 1'b1) begin
        ov_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: out_valid with no pending pixel (t=%0t)", $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_latency", 32'(edge_cnt - mon_e.acc + 1), 32'd9);
          for (int k = 0; k < N_W; k++)
            check($sformatf("sb_d%0d", k), 32'(d_dut[k]), 32'(mon_e.d[k]));
        end
      end
    end
  end

  initial begin
    logic [DIST_W-1:0] tbl [N_W];
    logic [PIX_W-1:0]  w5_before;
    int                ov_before;

    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state.
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < N_W; k++) begin
      check($sformatf("rst_d%0d", k), 32'(d_dut[k]), 32'd0);
      check($sformatf("rst_w%0d", k), 32'(w_dut[k]), 32'd0);
    end

    // Nominal: w_k = k*0x101010, pixel 0x303030.
    for (int k = 0; k < N_W; k++) load_w(k, PIX_W'(k * 32'h101010));
    send_pix(24'h303030);
    wait_idle();
`ifdef DIST_8_GREEN_WEIGHT_EN
    tbl = '{11'd192, 11'd128, 11'd64, 11'd0, 11'd64, 11'd128, 11'd192, 11'd256};
`else
    tbl = '{11'd144, 11'd96, 11'd48, 11'd0, 11'd48, 11'd96, 11'd144, 11'd192};
`endif
    check_table("nominal", tbl);

    // Extremes: all weights zero, white pixel.
    for (int k = 0; k < N_W; k++) load_w(k, 24'h000000);
    send_pix(24'hFFFFFF);
    wait_idle();
`ifdef DIST_8_GREEN_WEIGHT_EN
    for (int k = 0; k < N_W; k++) tbl[k] = 11'd1020;
`else
    for (int k = 0; k < N_W; k++) tbl[k] = 11'd765;
`endif
    check_table("extreme", tbl);

    // Abort: reset in the 4th CALC cycle.
    for (int k = 0; k < N_W; k++) load_w(k, PIX_W'(k * 32'h0A0B0C));
    ov_before = ov_cnt;
    send_pix(24'h808080);
    repeat (3) tick();
    do_reset();
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < N_W; k++) tbl[k] = '0;
    check_table("abort", tbl);
    repeat (12) tick();
    check("abort_no_ov", 32'(ov_cnt - ov_before), 32'd0);
    send_pix(24'h102030);
    wait_idle();

    // Busy: writes and pixels offered during CALC are ignored.
    for (int k = 0; k < N_W; k++) load_w(k, PIX_W'($urandom));
    w5_before = bank_m[5];
    ov_before = ov_cnt;
    send_pix(24'h123456);
    bus.w_load   = 1'b1;
    bus.w_idx    = 3'd5;
    bus.w_data   = 24'hFFFFFF;
    bus.in_valid = 1'b1;
    bus.pixel    = 24'hABCDEF;
    repeat (5) tick();
    clear_inputs();
    wait_idle();
    repeat (3) tick();
    check("busy_w5", 32'(bus.w5), 32'(w5_before));
    check("busy_single_ov", 32'(ov_cnt - ov_before), 32'd1);

    // Collision: weight write and pixel accept on the same edge.
    bus.w_load   = 1'b1;
    bus.w_idx    = 3'd2;
    bus.w_data   = 24'h303030;
    bus.in_valid = 1'b1;
    bus.pixel    = 24'h303030;
    tick();
    clear_inputs();
    wait_idle();
    check("collide_d2", 32'(bus.d2), 32'd0);
    check("collide_w2", 32'(bus.w2), 32'h303030);

    // Random traffic, including occasional resets mid-computation.
    for (int i = 0; i < 1500; i++) begin
      rst          = ($urandom_range(0, 96) == 0);
      bus.w_load   = ($urandom_range(0, 3) == 0);
      bus.w_idx    = IDX_W'($urandom_range(0, 7));
      bus.w_data   = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : PIX_W'($urandom);
      bus.in_valid = ($urandom_range(0, 2) == 0);
      bus.pixel    = ($urandom_range(0, 7) == 0) ? 24'h000000 : PIX_W'($urandom);
      tick();
    end
    clear_inputs();
    wait_idle();
    tick();
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
